tri_array_sched: RTL

//   Owns and sequences a lower-triangular N x N bit array arr[a][b], b<a.
//   Two requesters issue single-row writes through a round-robin arbiter.
//   A sweep FSM rewrites every row from one (N+1)-bit vector, one row per

---
 rtl/tri_array_sched.sv | 112 +++++++++++
 1 files changed

// File: rtl/tri_array_sched.sv
// Lower-triangular N x N bit array with round-robin row writes from two
// requesters and a one-row-per-cycle sweep that rewrites the whole array.
module tri_array_sched #(
  parameter int N = 16,
  parameter int M = 5,
  localparam int ROW_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [ROW_W-1:0]   req0_row,
  input  logic [N-1:0]       req0_data,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [ROW_W-1:0]   req1_row,
  input  logic [N-1:0]       req1_data,
  input  logic               sweep_start,
  input  logic [N:0]         sweep_in,
  output logic               busy,
  output logic               done,
  output logic [N*N-1:0]     out
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t                 state_q;
  logic [ROW_W-1:0]       rowCnt_q;
  logic [N:0]             sweepVec_q;
  logic                   rrPtr_q, rrPtr_d;
  logic                   busy_q, done_q;
  logic [N-1:0][N-1:0]    arr_q, arr_d;

  logic                   acceptOk, grant0, grant1, wrEn, wrSel;
  logic [ROW_W-1:0]       wrRow;
  logic [N-1:0]           wrData;
  logic                   unusedBits;

  // A pending sweep start takes the cycle away from both requesters.
  assign acceptOk   = (state_q == IDLE) && !rst && !sweep_start;
  assign grant0     = req0_valid && (!req1_valid || !rrPtr_q);
  assign grant1     = req1_valid && (!req0_valid ||  rrPtr_q);
  assign req0_ready = acceptOk && grant0;
  assign req1_ready = acceptOk && grant1;

  assign wrEn    = req0_ready || req1_ready;
  assign wrSel   = req1_ready;
  assign wrRow   = wrSel ? req1_row  : req0_row;
  assign wrData  = wrSel ? req1_data : req0_data;
  assign rrPtr_d = wrEn ? !wrSel : rrPtr_q;

  // Bits on or above the diagonal are never written, so they stay at reset 0.
  always_comb begin
    arr_d = arr_q;
    for (int a = 1; a < N; a++) begin
      if (wrEn && (wrRow == ROW_W'(a))) begin
        for (int b = 0; b < a; b++) arr_d[a][b] = wrData[b];
      end
      if ((state_q == SWEEP) && (rowCnt_q == ROW_W'(a))) begin
        for (int b = 0; b < a; b++)
          arr_d[a][b] = ((a / M) == (b / M)) ? sweepVec_q[a] : ~sweepVec_q[a+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rowCnt_q   <= '0;
      sweepVec_q <= '0;
      rrPtr_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      arr_q      <= '0;
    end else begin
      arr_q   <= arr_d;
      rrPtr_q <= rrPtr_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sweep_start) begin
            state_q    <= SWEEP;
            sweepVec_q <= sweep_in;
            rowCnt_q   <= '0;
            busy_q     <= 1'b1;
          end
        end
        SWEEP: begin
          if (rowCnt_q == ROW_W'(N-1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            rowCnt_q <= rowCnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = arr_q;

  // Row data's top bit and sweep bit 0 can never reach a stored cell.
  assign unusedBits = ^{wrData[N-1], sweepVec_q[0]};

endmodule
